// File: rtl/fetch_queue.sv
// Instruction fetch stage with a small prefetch FIFO feeding decode.
// Owns the fetch PC, drives the asynchronous ROM address, captures
// {instr, pc} pairs and hands the head entry to decode over valid/ready.
// A redirect flushes the buffer and restarts fetch at the target PC.
module fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [WIDTH-1:0]           imem_addr,
  input  logic [WIDTH-1:0]           imem_rdata,
  input  logic                       redirect_valid,
  input  logic [WIDTH-1:0]           redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_instr,
  output logic [WIDTH-1:0]           out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]    count_reg, count_next;

  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];

  logic pop;
  logic push;

  // A full buffer can still accept a word when the head leaves the same cycle.
  assign pop  = out_valid && out_ready;
  assign push = !redirect_valid && ((count_reg < CW'(DEPTH)) || pop);

  assign imem_addr = fetch_pc_reg;
  assign out_valid = (count_reg != '0);
  assign out_instr = instr_mem[rd_ptr_reg];
  assign out_pc    = pc_mem[rd_ptr_reg];
  assign count     = count_reg;

  // Next-state for PC, pointers and occupancy; redirect overrides push/pop.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    if (redirect_valid) begin
      // Flush discards any concurrent pop; the target is word aligned.
      fetch_pc_next = {redirect_pc[WIDTH-1:2], 2'b00};
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
    end else begin
      if (push) begin
        wr_ptr_next   = wr_ptr_reg + PW'(1);
        fetch_pc_next = fetch_pc_reg + WIDTH'(4);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state register; reset beats redirect and handshake traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
    end
  end

  // Per-entry storage; contents are don't-care after reset, so no reset here.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Capture the fetched word and its PC when this slot is the write target.
    always_ff @(posedge clk) begin
      if (!rst && push && (wr_ptr_reg == PW'(gi))) begin
        instr_mem[gi] <= imem_rdata;
        pc_mem[gi]    <= fetch_pc_reg;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rom_key = 32'h0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t      model_q[$];
  logic [31:0] model_pc;

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .count         (count)
  );

  always #5 clk = ~clk;

  // ROM: word index, optionally scrambled by a key.
  always_comb imem_rdata = (imem_addr >> 2) ^ rom_key;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a >> 2) ^ rom_key;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check_val("count", {29'b0, count}, 32'(model_q.size()));
    check_val("out_valid", {31'b0, out_valid}, {31'b0, model_q.size() != 0});
    check_val("imem_addr", imem_addr, model_pc);
    if (model_q.size() != 0) begin
      check_val("out_pc", out_pc, model_q[0].pc);
      check_val("out_instr", out_instr, model_q[0].instr);
    end
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic do_pop;
    logic do_push;
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    if (r) begin
      model_q.delete();
      model_pc = RESET_PC;
    end else if (rv) begin
      model_q.delete();
      model_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      do_pop  = (model_q.size() > 0) && rdy;
      do_push = (model_q.size() < DEPTH) || do_pop;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back('{instr: rom_word(model_pc), pc: model_pc});
        model_pc = model_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    $display("cyc rst=%0b rv=%0b rpc=%h rdy=%0b -> cnt=%0d vld=%0b pc=%h instr=%h addr=%h",
             r, rv, rpc, rdy, count, out_valid, out_pc, out_instr, imem_addr);
    compare_all();
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    model_pc = RESET_PC;

    // Reset state.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    check_val("rst_count", {29'b0, count}, 32'd0);
    check_val("rst_addr", imem_addr, RESET_PC);

    // Streaming after reset release: one instruction per cycle.
    cycle(0, 0, 0, 1);
    check_val("first_valid", {31'b0, out_valid}, 32'd1);
    check_val("first_pc", out_pc, 32'd0);
    for (int k = 1; k < 4; k++) begin
      cycle(0, 0, 0, 1);
      check_val("stream_pc", out_pc, 32'(4 * k));
      check_val("stream_instr", out_instr, 32'(k));
    end

    // Back-pressure fill, then drain with no gap.
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) cycle(0, 0, 0, 0);
    check_val("full_count", {29'b0, count}, 32'd4);
    check_val("full_addr", imem_addr, 32'd16);
    for (int k = 0; k < 5; k++) begin
      check_val("drain_pc", out_pc, 32'(4 * k));
      cycle(0, 0, 0, 1);
      if (k == 0) begin
        check_val("fullpop_count", {29'b0, count}, 32'd4);
        check_val("fullpop_addr", imem_addr, 32'd20);
      end
    end

    // Redirect with three entries buffered.
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0);
    check_val("pre_redir_count", {29'b0, count}, 32'd3);
    cycle(0, 1, 32'h0000_0043, 1);
    check_val("redir_count", {29'b0, count}, 32'd0);
    check_val("redir_valid", {31'b0, out_valid}, 32'd0);
    check_val("redir_addr", imem_addr, 32'h0000_0040);
    cycle(0, 0, 0, 1);
    check_val("redir_head_valid", {31'b0, out_valid}, 32'd1);
    check_val("redir_head_pc", out_pc, 32'h0000_0040);

    // PC wrap-around.
    cycle(0, 1, 32'hFFFF_FFFC, 1);
    cycle(0, 0, 0, 1);
    check_val("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1);
    check_val("wrap_pc1", out_pc, 32'h0000_0000);

    // Back-to-back redirects: last one wins.
    cycle(0, 1, 32'h0000_0200, 1);
    cycle(0, 1, 32'h0000_0300, 1);
    check_val("b2b_valid", {31'b0, out_valid}, 32'd0);
    cycle(0, 0, 0, 1);
    check_val("b2b_pc", out_pc, 32'h0000_0300);

    // Reset while full and redirecting.
    for (int k = 0; k < 6; k++) cycle(0, 0, 0, 0);
    cycle(1, 1, 32'h0000_0100, 0);
    check_val("rst_redir_count", {29'b0, count}, 32'd0);
    check_val("rst_redir_addr", imem_addr, RESET_PC);
    cycle(0, 0, 0, 1);
    check_val("rst_redir_pc", out_pc, RESET_PC);

    // Randomized traffic.
    rom_key = $urandom();
    for (int k = 0; k < 2000; k++) begin
      logic r, rv, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 49) == 0);
      rv  = ($urandom_range(0, 7) == 0);
      rpc = $urandom();
      rdy = ($urandom_range(0, 9) < 7);
      cycle(r, rv, rpc, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
